// File: rtl/alu_sequencer.sv
// Sequential front end for the 64-bit ALU: request/response handshakes around an EXEC beat.
// Define ALU_SEQ_FLAGS_EN to add a PASSFLAG beat that returns the ALU flag register in rsp_flags.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cmd,
    input  logic [6:0]  req_opm,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [4:0]  alu_cmd,
    output logic [6:0]  alu_opm,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [63:0] rsp_flags,
    output logic        rsp_err,
    output logic [31:0] op_count
);

    localparam logic [4:0] CMD_PASSFLAG = 5'd2;
    localparam logic [4:0] CMD_MAX      = 5'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLAGS = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;

    function automatic logic cmd_illegal(input logic [4:0] cmd);
        return cmd > CMD_MAX;
    endfunction

`ifndef ALU_SEQ_FLAGS_EN
    assign rsp_flags = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_flags <= '0;
`endif
            rsp_err   <= 1'b0;
            op_count  <= '0;
            alu_cmd   <= CMD_PASSFLAG;
            alu_opm   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_cmd   <= req_cmd;
                        alu_opm   <= req_opm;
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        rsp_err   <= cmd_illegal(req_cmd);
                        req_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
`ifdef ALU_SEQ_FLAGS_EN
                    // Operands stay put so PASSFLAG reads the flags this operation produced.
                    alu_cmd  <= CMD_PASSFLAG;
                    state    <= FLAGS;
`else
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`endif
                end
                FLAGS: begin
`ifdef ALU_SEQ_FLAGS_EN
                    rsp_flags <= alu_out;
`endif
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count  <= op_count + 32'd1;
                        alu_cmd   <= CMD_PASSFLAG;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
